fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  - Shares the async FIFO write port among NUM_REQ producers in the write clock domain.
//  - Round-robin arbitration with bounded bursts: each producer owns the port for up to MAX_BURST beats.
//  - Producer valid/ready handshakes map to the FIFO wr_data/wr_en/full interface.
// PARAMETERS
//  DATA_WIDTH  16  width of each producer word and of wr_data
//  NUM_REQ     4   number of producers, 2..8
//  MAX_BURST   4   max beats accepted per grant, 1..16
// PORTS
//  wr_clk      in   1                     write-domain clock
//  wr_rst      in   1                     reset; asynchronous, active-high
//  req_valid   in   NUM_REQ               producer i has a word
//  req_data    in   NUM_REQ*DATA_WIDTH    flat; producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready   out  NUM_REQ               word of producer i accepted this cycle when valid&ready
//  full        in   1                     FIFO full flag (write domain)
//  wr_en       out  1                     FIFO write enable
//  wr_data     out  DATA_WIDTH            FIFO write data
//  grant_id    out  $clog2(NUM_REQ)       current owner; 0 when idle
//  busy        out  1                     1 in BURST state
// BEHAVIOUR
//  - FSM states IDLE, BURST. Registers: state, owner, rr_ptr, beat_cnt.
//  - Reset values: state=IDLE, owner=0, rr_ptr=0, beat_cnt=0.
//  - Reset output values: req_ready=0, wr_en=0, wr_data=0, grant_id=0, busy=0.
//  - IDLE: if |req_valid, owner <= first i with req_valid[i], searching from rr_ptr upward with wrap.
//    Then beat_cnt <= 0 and go to BURST. No write occurs in the IDLE cycle (1-cycle arbitration latency).
//  - BURST, combinational outputs:
//    - req_ready[owner] = !full; all other ready bits = 0.
//    - wr_en = req_valid[owner] & !full.
//    - wr_data = req_data[owner].
//    - Zero latency from producer to FIFO.
//  - BURST exits to IDLE with rr_ptr <= (owner+1) mod NUM_REQ when either:
//    (a) a beat is accepted and beat_cnt == MAX_BURST-1, or
//    (b) req_valid[owner] == 0 and full == 0.
//  - On an accepted beat that does not exit, beat_cnt <= beat_cnt+1.
//  - full=1 in BURST: stall; no write, no counting, owner is held even if its valid drops (no exit on (b)).
//  - Producers must hold req_data stable while valid && !ready.
//  - A producer that deasserts valid ends its burst; it re-arbitrates only after all others get a turn.
//  - grant_id = owner in BURST, 0 in IDLE. busy = (state==BURST).
//  - Reset mid-burst: asynchronous return to reset values; wr_en drops immediately and beats are not replayed.
//  - wr_en is never asserted while full=1 (FIFO overflow is impossible through this block).
// CONFIGURATION
//  - FIFO_ARB_STATS_EN defined:
//    - Adds output port grant_count [NUM_REQ*16], flat, one 16-bit counter per producer.
//    - Each counter increments per accepted beat, saturates at 16'hFFFF, and resets to 0.
//  - Not defined: port and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package fifo_arb_pkg holds:
//    - typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t
//    - localparam STATS_W = 16
//  - Sub-module fifo_arb_rr_pick: combinational; inputs req vector and rr_ptr; outputs found flag and index.
//  - Top holds FSM, counters, output mux.
// TESTING  (DATA_WIDTH=16, NUM_REQ=4, MAX_BURST=4, FIFO depth 16)
//  1. Reset: wr_rst=1 with req_valid=4'hF -> wr_en=0, req_ready=0, busy=0, grant_id=0.
//  2. Single producer 1 streams 0x1234,0x0000,0x0001 ->
//     - FIFO receives the words in order, first one 1 cycle after valid.
//     - Burst ends on valid drop; rr_ptr=2.
//  3. All four valid, each streaming 8 words ->
//     - Grant order 0,1,2,3,0,...
//     - Each grant writes exactly 4 beats, with 1 idle cycle between grants.
//  4. full forced high mid-burst after beat 2 for 5 cycles ->
//     - wr_en=0 and ready=0 throughout; owner and beat_cnt hold.
//     - Beats 3,4 are written after release.
//  5. Reset pulse during beat 3 of a burst ->
//     - wr_en drops in the same cycle.
//     - After release, arbitration restarts from producer 0.
//  6. FIFO_ARB_STATS_EN: test 3 run for 10 grants ->
//     - grant_count = {8,8,12,12} for producers {3,2,1,0}.
//  - All tests: a scoreboard checks every FIFO word against the producer queues and checks that no write occurs while full=1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types for the FIFO write-port arbiter.
// Used by fifo_arb_rr_pick and fifo_wr_arbiter.
package fifo_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
  localparam int STATS_W = 16;
endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Round-robin picker: first set request at or above rr_ptr, with wrap.
// Purely combinational.
module fifo_arb_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  int j;

  // Walk downward so the closest match to rr_ptr is written last.
  always_comb begin
    found = |req;
    idx   = '0;
    j     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req[j]) idx = IDX_W'(j);
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter for an async FIFO write port.
// Define FIFO_ARB_STATS_EN to add per-producer grant_count counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0]    grant_count
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] TOP  = IDX_W'(NUM_REQ - 1);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             own_valid;

  fifo_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_q),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  assign own_valid = req_valid[owner_q];

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    wr_en     = 1'b0;
    wr_data   = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          cnt_d   = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        req_ready[owner_q] = !full;
        wr_en   = own_valid && !full;
        wr_data = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
        // A full stall never ends the burst, even if valid drops.
        if ((wr_en && cnt_q == LAST) || (!own_valid && !full)) begin
          state_d = ARB_IDLE;
          rr_d    = (owner_q == TOP) ? '0 : owner_q + 1'b1;
        end else if (wr_en) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy     = (state_q == ARB_BURST);
  assign grant_id = busy ? owner_q : '0;

`ifdef FIFO_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
    logic [STATS_W-1:0] cnt;
    always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst)
        cnt <= '0;
      else if (wr_en && owner_q == IDX_W'(i) && cnt != '1)
        cnt <= cnt + 1'b1;
    end
    assign grant_count[i*STATS_W +: STATS_W] = cnt;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized bench for fifo_wr_arbiter with a queue-based reference model.
// Build with FIFO_ARB_STATS_EN to also check grant_count.
module tb_fifo_wr_arbiter;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int MB = 4;
  localparam int IW = 2;
  localparam int DEPTH = 16;

  logic             wr_clk = 1'b0;
  logic             wr_rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic             full = 1'b0;
  logic             wr_en;
  logic [DW-1:0]    wr_data;
  logic [IW-1:0]    grant_id;
  logic             busy;
`ifdef FIFO_ARB_STATS_EN
  logic [NR*16-1:0] grant_count;
`endif

  always #5 wr_clk = ~wr_clk;

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_BURST  (MB)
  ) dut (
    .wr_clk      (wr_clk),
    .wr_rst      (wr_rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .full        (full),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .grant_id    (grant_id),
`ifdef FIFO_ARB_STATS_EN
    .grant_count (grant_count),
`endif
    .busy        (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int drop_pct = 0;
  int fifo_cnt = 0;

  // Producer word queues and the log of words seen at the FIFO.
  logic [DW-1:0] src [NR][$];
  int            wl_id [$];
  int            wl_cyc [$];
  logic [DW-1:0] wl_data [$];

  // Reference model: who owns the port, beats taken, where the search starts.
  bit m_busy = 0;
  int m_owner = 0;
  int m_beats = 0;
  int m_rr = 0;
  int m_cnt [NR];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic model_cycle(input bit rst);
    logic [NR-1:0] e_ready;
    bit            e_en;
    logic [DW-1:0] e_data;
    int            e_gid;
    e_ready = '0;
    e_en    = 0;
    e_data  = '0;
    e_gid   = 0;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_beats = 0; m_rr = 0;
      for (int i = 0; i < NR; i++) m_cnt[i] = 0;
    end
    if (m_busy) begin
      e_ready[m_owner] = !full;
      e_en  = req_valid[m_owner] && !full;
      e_gid = m_owner;
      if (src[m_owner].size() > 0) e_data = src[m_owner][0];
    end
    check("busy", 64'(busy), 64'(m_busy));
    check("grant_id", 64'(grant_id), 64'(e_gid));
    check("req_ready", 64'(req_ready), 64'(e_ready));
    check("wr_en", 64'(wr_en), 64'(e_en));
    if (full) check("wr_en_while_full", 64'(wr_en), 64'(0));
    if (e_en) check("wr_data", 64'(wr_data), 64'(e_data));
`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NR; i++)
      check("grant_count", 64'(grant_count[i*16 +: 16]), 64'(m_cnt[i]));
`endif
    if (rst) return;
    if (!m_busy) begin
      for (int k = NR - 1; k >= 0; k--)
        if (req_valid[(m_rr + k) % NR]) begin
          m_busy  = 1;
          m_owner = (m_rr + k) % NR;
          m_beats = 0;
        end
    end else if (e_en) begin
      wl_id.push_back(m_owner);
      wl_cyc.push_back(cyc);
      wl_data.push_back(e_data);
      void'(src[m_owner].pop_front());
      fifo_cnt++;
      if (m_cnt[m_owner] < 16'hFFFF) m_cnt[m_owner]++;
      m_beats++;
      if (m_beats == MB) begin
        m_busy = 0;
        m_rr = (m_owner + 1) % NR;
      end
    end else if (!req_valid[m_owner] && !full) begin
      m_busy = 0;
      m_rr = (m_owner + 1) % NR;
    end
  endtask

  // full_ctl: 0 = low, 1 = forced high, 2 = from a depth-16 FIFO model.
  task automatic step(input bit rst, input int full_ctl);
    @(posedge wr_clk);
    #1;
    wr_rst = rst;
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = (src[i].size() > 0) &&
                     ($urandom_range(99) >= 32'(drop_pct));
      req_data[i*DW +: DW] = (src[i].size() > 0) ? src[i][0] : DW'($urandom);
    end
    if (full_ctl == 2 && fifo_cnt > 0 && $urandom_range(2) == 0)
      fifo_cnt--;
    if (full_ctl != 2) fifo_cnt = 0;
    full = (full_ctl == 1) || (full_ctl == 2 && fifo_cnt >= DEPTH);
    @(negedge wr_clk);
    model_cycle(rst);
    cyc++;
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) src[i].delete();
    wl_id.delete();
    wl_cyc.delete();
    wl_data.delete();
  endtask

  task automatic do_reset();
    clear_all();
    step(1, 0);
    step(1, 0);
  endtask

  int c0;

  initial begin
    // Reset with every producer requesting.
    drop_pct = 0;
    clear_all();
    for (int i = 0; i < NR; i++) src[i].push_back(DW'(i + 1));
    step(1, 0);
    check("t1_wr_en", 64'(wr_en), 64'(0));
    check("t1_ready", 64'(req_ready), 64'(0));
    check("t1_busy", 64'(busy), 64'(0));
    check("t1_grant", 64'(grant_id), 64'(0));
    clear_all();
    step(1, 0);
    step(0, 0);

    // Single producer 1 streams three words.
    c0 = cyc;
    src[1].push_back(16'h1234);
    src[1].push_back(16'h0000);
    src[1].push_back(16'h0001);
    for (int k = 0; k < 6; k++) step(0, 0);
    check("t2_count", 64'(wl_data.size()), 64'(3));
    if (wl_data.size() == 3) begin
      check("t2_w0", 64'(wl_data[0]), 64'h1234);
      check("t2_w1", 64'(wl_data[1]), 64'h0000);
      check("t2_w2", 64'(wl_data[2]), 64'h0001);
      check("t2_lat", 64'(wl_cyc[0]), 64'(c0 + 1));
    end
    src[0].push_back(16'hAAAA);
    src[2].push_back(16'hBBBB);
    step(0, 0);
    step(0, 0);
    check("t2_rr_next", 64'(grant_id), 64'(2));
    for (int k = 0; k < 8; k++) step(0, 0);

    // All four producers streaming; 10 grants in total.
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int n = 0; n < ((i < 2) ? 12 : 8); n++)
        src[i].push_back(DW'($urandom));
    c0 = cyc;
    for (int k = 0; k < 60; k++) step(0, 0);
    check("t3_count", 64'(wl_id.size()), 64'(40));
    if (wl_id.size() == 40) begin
      check("t3_first", 64'(wl_cyc[0]), 64'(c0 + 1));
      for (int n = 0; n < 40; n++) begin
        check("t3_order", 64'(wl_id[n]), 64'((n / 4) % 4));
        check("t3_gap", 64'(wl_cyc[n] - wl_cyc[0]), 64'(n + n / 4));
      end
    end
`ifdef FIFO_ARB_STATS_EN
    check("t6_gc", 64'(grant_count), 64'h0008_0008_000C_000C);
`endif

    // full held high for 5 cycles after beat 2.
    do_reset();
    for (int n = 0; n < 4; n++) src[0].push_back(DW'(16'h4000 + n));
    c0 = cyc;
    for (int k = 0; k < 12; k++) begin
      step(0, (k >= 3 && k <= 7) ? 1 : 0);
      if (k >= 3 && k <= 7) begin
        check("t4_stall_en", 64'(wr_en), 64'(0));
        check("t4_stall_rdy", 64'(req_ready), 64'(0));
        check("t4_stall_busy", 64'(busy), 64'(1));
      end
    end
    check("t4_count", 64'(wl_cyc.size()), 64'(4));
    if (wl_cyc.size() == 4) begin
      check("t4_b1", 64'(wl_cyc[0]), 64'(c0 + 1));
      check("t4_b2", 64'(wl_cyc[1]), 64'(c0 + 2));
      check("t4_b3", 64'(wl_cyc[2]), 64'(c0 + 8));
      check("t4_b4", 64'(wl_cyc[3]), 64'(c0 + 9));
    end

    // Reset pulse during beat 3.
    do_reset();
    for (int n = 0; n < 8; n++) src[0].push_back(DW'(16'h5000 + n));
    step(0, 0);
    step(0, 0);
    step(0, 0);
    step(1, 0);
    check("t5_en_drop", 64'(wr_en), 64'(0));
    check("t5_written", 64'(wl_data.size()), 64'(2));
    for (int n = 0; n < 4; n++) src[2].push_back(DW'(16'h6000 + n));
    step(0, 0);
    step(0, 0);
    check("t5_restart", 64'(grant_id), 64'(0));
    for (int k = 0; k < 20; k++) step(0, 0);

    // Random traffic with a real FIFO occupancy model and random resets.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 0) drop_pct = $urandom_range(40);
      for (int i = 0; i < NR; i++)
        if (src[i].size() < 6 && $urandom_range(3) == 0)
          src[i].push_back(DW'($urandom));
      step($urandom_range(400) == 0, 2);
    end
    drop_pct = 0;
    step(0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
